// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - ping-pong frame collector feeding the fft load port
// Optional build macro: CHANNEL_MIX_EN (mono mix of left+right instead of left only).
module fft_frame_loader #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [23:0]      left,
  input  logic [23:0]      right,
  output logic             fft_load,
  output logic [width-1:0] fft_rd,
  output logic             fft_start,
  input  logic             fft_done,
  output logic             overrun
);

  localparam int N = 1 << N_2;
  localparam logic [N_2-1:0] LAST = N_2'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t           state, state_next;
  logic [width-1:0] mem [2][N];
  logic             wr_bank, rd_bank, blocked, done_q;
  logic [N_2-1:0]   wr_ptr, rd_idx;
  logic [1:0]       full, full_next;
  logic [width-1:0] s;
  logic             accept, fill_done, free_now, other_empty;

`ifdef CHANNEL_MIX_EN
  logic [24:0] mix_sum;
  logic [23:0] mix_m;
  logic        unused_bits;
  // Sign-extended 25-bit sum cannot overflow; halving brings it back to 24 bits.
  assign mix_sum     = {left[23], left} + {right[23], right};
  assign mix_m       = mix_sum[24:1];
  assign s           = mix_m[23:24-width];
  assign unused_bits = ^{mix_sum[0], mix_m[23-width:0]};
`else
  logic unused_bits;
  // Left channel only; low bits are truncated without rounding.
  assign s           = left[23:24-width];
  assign unused_bits = ^{right, left[23-width:0]};
`endif

  assign accept    = sample_valid && !blocked;
  assign fill_done = accept && (wr_ptr == LAST);
  assign free_now  = (state == LOAD) && (rd_idx == LAST);
  // A bank released by the drain in this very cycle already counts as empty.
  assign other_empty = !full[~wr_bank] || (free_now && (rd_bank == ~wr_bank));

  // Bank occupancy: drain frees its bank, fill marks its bank; never the same bank.
  always_comb begin
    full_next = full;
    if (free_now)  full_next[rd_bank] = 1'b0;
    if (fill_done) full_next[wr_bank] = 1'b1;
  end

  // Sample storage, written only by the fill side.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wr_ptr] <= s;
  end

  // Fill side: write pointer, bank toggle, blocking and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      blocked <= 1'b0;
      overrun <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_next;
      if (accept) begin
        wr_ptr <= wr_ptr + N_2'(1);
        if (fill_done) begin
          if (other_empty) wr_bank <= ~wr_bank;
          else             blocked <= 1'b1;
        end
      end else if (blocked) begin
        if (sample_valid) overrun <= 1'b1;
        if (!full[~wr_bank]) begin
          blocked <= 1'b0;
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // Drain side registers: state, read bank/index, previous fft_done level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= fft_done;
      if (state == IDLE && (|full)) begin
        rd_bank <= !full[0];
        rd_idx  <= '0;
      end else if (state == LOAD) begin
        rd_idx <= rd_idx + N_2'(1);
      end
    end
  end

  // Drain next-state and outputs; the load data is a same-cycle buffer read.
  always_comb begin
    state_next = state;
    fft_load   = 1'b0;
    fft_start  = 1'b0;
    fft_rd     = '0;
    case (state)
      IDLE: begin
        if (|full) state_next = LOAD;
      end
      LOAD: begin
        fft_load = 1'b1;
        fft_rd   = mem[rd_bank][rd_idx];
        if (rd_idx == LAST) state_next = START;
      end
      START: begin
        fft_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (fft_done && !done_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
